// File: rtl/vc_xmem_pkg.sv
// Shared types and codes for the vc external memory arbiter.
package vc_xmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A2,
        A1,
        A0,
        TA,
        D0,
        D1,
        ACK
    } xmem_state_t;

    localparam logic [1:0] ALE_NONE = 2'd0;
    localparam logic [1:0] ALE_B0   = 2'd1;
    localparam logic [1:0] ALE_B1   = 2'd2;
    localparam logic [1:0] ALE_B2   = 2'd3;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/vc_xmem_rr2.sv
// Two-way round-robin arbiter; req[0] = I, req[1] = D.
module vc_xmem_rr2
    import vc_xmem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_last == GNT_I) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/vc_xmem_arb.sv
// Byte-serial external memory sequencer shared by fetch (I) and load/store (D).
module vc_xmem_arb
    import vc_xmem_pkg::*;
#(
    parameter int PA   = 24,
    parameter int WAIT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [PA-1:0] i_addr,
    output logic          i_ack,
    output logic [15:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_be,
    input  logic [PA-1:0] d_addr,
    input  logic [15:0]   d_wdata,
    output logic          d_ack,
    output logic [15:0]   d_rdata,
    input  logic [7:0]    bus_in,
    output logic [7:0]    bus_out,
    output logic [7:0]    bus_oe,
    output logic [1:0]    bus_ale,
    output logic          bus_rd_n,
    output logic          bus_wr_n,
    output logic          busy
);

    localparam logic [3:0] LW = 4'(WAIT);

    xmem_state_t   r_state, w_nxt;
    logic [3:0]    r_wcnt;
    logic          r_gid, r_last, r_we;
    logic [1:0]    r_be;
    logic [PA-1:0] r_addr;
    logic [15:0]   r_wdata;
    logic [7:0]    r_lo;

    logic [7:0]    r_bus_out;
    logic          r_oe, r_rd_n, r_wr_n, r_busy;
    logic [1:0]    r_ale;
    logic          r_i_ack, r_d_ack;
    logic [15:0]   r_i_rdata, r_d_rdata;

    logic [1:0]    w_gnt;
    logic          w_idle, w_gid, w_we, w_done;
    logic [1:0]    w_be;
    logic [PA-1:0] w_addr;
    logic [15:0]   w_wdata;
    logic [23:0]   w_a24;

    logic          w_oe, w_rd_n, w_wr_n;
    logic [7:0]    w_out;
    logic [1:0]    w_ale;

    vc_xmem_rr2 u_rr (
        .i_req  ({d_req, i_req}),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    // In IDLE the request inputs are used directly so the first
    // address byte can be registered on the grant edge.
    assign w_idle  = (r_state == IDLE);
    assign w_gid   = w_idle ? (w_gnt[1] ? GNT_D : GNT_I) : r_gid;
    assign w_we    = w_idle ? (w_gnt[1] & d_we) : r_we;
    assign w_be    = w_idle ? d_be : r_be;
    assign w_wdata = w_idle ? d_wdata : r_wdata;
    assign w_addr  = w_idle ? (w_gnt[1] ? d_addr : i_addr) : r_addr;
    assign w_a24   = 24'(w_addr) & ~24'd1;
    assign w_done  = (r_wcnt == LW);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE: if (|w_gnt) w_nxt = (PA == 16) ? A1 : A2;
            A2:   w_nxt = A1;
            A1:   w_nxt = A0;
            A0: begin
                if (!w_we)         w_nxt = TA;
                else if (w_be[0])  w_nxt = D0;
                else if (w_be[1])  w_nxt = D1;
                else               w_nxt = ACK;
            end
            TA:   w_nxt = D0;
            D0: if (w_done) w_nxt = (!w_we || w_be[1]) ? D1 : ACK;
            D1: if (w_done) w_nxt = ACK;
            ACK:  w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_oe   = 1'b0;
        w_out  = 8'h00;
        w_ale  = ALE_NONE;
        w_rd_n = 1'b1;
        w_wr_n = 1'b1;
        case (w_nxt)
            A2: begin
                w_oe  = 1'b1;
                w_out = w_a24[23:16];
                w_ale = ALE_B2;
            end
            A1: begin
                w_oe  = 1'b1;
                w_out = w_a24[15:8];
                w_ale = ALE_B1;
            end
            A0: begin
                w_oe  = 1'b1;
                w_out = w_a24[7:0];
                w_ale = ALE_B0;
            end
            D0: begin
                if (w_we) begin
                    w_oe   = 1'b1;
                    w_out  = w_wdata[7:0];
                    w_wr_n = 1'b0;
                end else begin
                    w_rd_n = 1'b0;
                end
            end
            D1: begin
                if (w_we) begin
                    w_oe   = 1'b1;
                    w_out  = w_wdata[15:8];
                    w_wr_n = 1'b0;
                end else begin
                    w_rd_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wcnt    <= '0;
            r_gid     <= GNT_I;
            r_last    <= GNT_I;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_lo      <= '0;
            r_bus_out <= '0;
            r_oe      <= 1'b0;
            r_ale     <= ALE_NONE;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_nxt;
            r_wcnt  <= (w_nxt != r_state) ? 4'd0 : r_wcnt + 4'd1;
            if (w_idle && (|w_gnt)) begin
                r_gid   <= w_gid;
                r_last  <= w_gid;
                r_we    <= w_we;
                r_be    <= w_be;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
            end
            if (r_state == D0 && w_done && !r_we)
                r_lo <= bus_in;
            if (r_state == D1 && w_done && !r_we) begin
                if (r_gid == GNT_D) r_d_rdata <= {bus_in, r_lo};
                else                r_i_rdata <= {bus_in, r_lo};
            end
            r_bus_out <= w_out;
            r_oe      <= w_oe;
            r_ale     <= w_ale;
            r_rd_n    <= w_rd_n;
            r_wr_n    <= w_wr_n;
            r_busy    <= (w_nxt != IDLE);
            r_i_ack   <= (w_nxt == ACK) && (w_gid == GNT_I);
            r_d_ack   <= (w_nxt == ACK) && (w_gid == GNT_D);
        end
    end

    assign bus_out  = r_bus_out;
    assign bus_oe   = {8{r_oe}};
    assign bus_ale  = r_ale;
    assign bus_rd_n = r_rd_n;
    assign bus_wr_n = r_wr_n;
    assign busy     = r_busy;
    assign i_ack    = r_i_ack;
    assign d_ack    = r_d_ack;
    assign i_rdata  = r_i_rdata;
    assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_vc_xmem_arb.sv
// Directed bench for vc_xmem_arb (WAIT=0 and WAIT=3 instances).
module tb_vc_xmem_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_req = 0, d_req = 0, d_we = 0;
    logic [23:0] i_addr = 0, d_addr = 0;
    logic [1:0]  d_be = 0;
    logic [15:0] d_wdata = 0;
    logic [7:0]  bus_in = 0;
    logic        i_ack, d_ack, bus_rd_n, bus_wr_n, busy;
    logic [15:0] i_rdata, d_rdata;
    logic [7:0]  bus_out, bus_oe;
    logic [1:0]  bus_ale;

    logic        x_i_req = 0, x_d_req = 0, x_d_we = 0;
    logic [23:0] x_i_addr = 0, x_d_addr = 0;
    logic [1:0]  x_d_be = 0;
    logic [15:0] x_d_wdata = 0;
    logic [7:0]  x_bus_in = 0;
    logic        x_i_ack, x_d_ack, x_rd_n, x_wr_n, x_busy;
    logic [15:0] x_i_rdata, x_d_rdata;
    logic [7:0]  x_bus_out, x_bus_oe;
    logic [1:0]  x_ale;

    int n_cmp = 0;
    int n_bad = 0;

    vc_xmem_arb #(.PA(24), .WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .bus_in(bus_in), .bus_out(bus_out),
        .bus_oe(bus_oe), .bus_ale(bus_ale),
        .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
        .busy(busy)
    );

    vc_xmem_arb #(.PA(24), .WAIT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_req(x_i_req), .i_addr(x_i_addr),
        .i_ack(x_i_ack), .i_rdata(x_i_rdata),
        .d_req(x_d_req), .d_we(x_d_we), .d_be(x_d_be),
        .d_addr(x_d_addr), .d_wdata(x_d_wdata),
        .d_ack(x_d_ack), .d_rdata(x_d_rdata),
        .bus_in(x_bus_in), .bus_out(x_bus_out),
        .bus_oe(x_bus_oe), .bus_ale(x_ale),
        .bus_rd_n(x_rd_n), .bus_wr_n(x_wr_n),
        .busy(x_busy)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus_out, bus_oe, bus_ale} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h want 0",
                     {bus_out, bus_oe, bus_ale});
        end
        n_cmp++;
        if ({bus_rd_n, bus_wr_n, i_ack, d_ack, busy} !== 5'b11000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 11000",
                     {bus_rd_n, bus_wr_n, i_ack, d_ack, busy});
        end
        n_cmp++;
        if ({i_rdata, d_rdata} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h want 0",
                     {i_rdata, d_rdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, bus_oe, x_busy} !== 10'h0) begin
            n_bad++;
            $display("FAIL reset_idle: got %h want 0",
                     {busy, bus_oe, x_busy});
        end
    endtask

    task automatic test_contention();
        logic seq [4];
        int k;
        int dup;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_in = 8'h77;
        i_addr = 24'h000100;
        d_addr = 24'h000200;
        d_we = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        k = 0;
        dup = 0;
        for (int c = 0; c < 100 && k < 4; c++) begin
            @(negedge clk);
            if (i_ack && d_ack) dup++;
            if (d_ack) begin seq[k] = 1'b1; k++; end
            else if (i_ack) begin seq[k] = 1'b0; k++; end
            if (k == 4) begin i_req = 1'b0; d_req = 1'b0; end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        n_cmp++;
        if (k !== 4 || dup !== 0) begin
            n_bad++;
            $display("FAIL rr_count: got %0d acks %0d dup want 4 0",
                     k, dup);
        end
        n_cmp++;
        if ({seq[0], seq[1], seq[2], seq[3]} !== 4'b1010) begin
            n_bad++;
            $display("FAIL rr_order: got %b want 1010 (1=D)",
                     {seq[0], seq[1], seq[2], seq[3]});
        end
        n_cmp++;
        if (d_rdata !== 16'h7777 || i_rdata !== 16'h7777) begin
            n_bad++;
            $display("FAIL rr_rdata: got %h %h want 7777 7777",
                     i_rdata, d_rdata);
        end
        dup = 0;
        repeat (4) begin
            @(negedge clk);
            if (i_ack || d_ack || busy) dup++;
        end
        n_cmp++;
        if (dup !== 0) begin
            n_bad++;
            $display("FAIL rr_quiet: got %0d active want 0", dup);
        end
    endtask

    task automatic test_i_read();
        logic [7:0] eo [1:3];
        logic [1:0] ea [1:3];
        int ack_c;
        int nz;
        int bad;
        eo[1] = 8'h12; eo[2] = 8'h34; eo[3] = 8'h56;
        ea[1] = 2'd3;  ea[2] = 2'd2;  ea[3] = 2'd1;
        ack_c = 0; nz = 0; bad = 0;
        i_addr = 24'h123456;
        i_req = 1'b1;
        for (int c = 1; c <= 30 && ack_c == 0; c++) begin
            @(negedge clk);
            if (c <= 3 && (bus_ale !== ea[c] || bus_out !== eo[c]
                           || bus_oe !== 8'hFF)) begin
                bad++;
                $display("FAIL i_addr_phase c%0d: got %0d/%h want %0d/%h",
                         c, bus_ale, bus_out, ea[c], eo[c]);
            end
            if (!i_ack && bus_oe === 8'h00) nz++;
            bus_in = (c == 5) ? 8'hCD : (c == 6) ? 8'hAB : 8'h00;
            if (i_ack) begin ack_c = c; i_req = 1'b0; end
        end
        n_cmp++;
        if (bad !== 0) n_bad++;
        n_cmp++;
        if (nz !== 3) begin
            n_bad++;
            $display("FAIL i_oe_low: got %0d cycles want 3", nz);
        end
        n_cmp++;
        if (ack_c !== 7) begin
            n_bad++;
            $display("FAIL i_latency: got %0d want 7", ack_c);
        end
        n_cmp++;
        if (i_rdata !== 16'hABCD) begin
            n_bad++;
            $display("FAIL i_rdata: got %h want abcd", i_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_d_write(input logic [1:0] be,
                                input int exp_ack,
                                input int exp_wr);
        int ack_c;
        int nw;
        logic [15:0] seen;
        logic [15:0] exp_seen;
        ack_c = 0; nw = 0; seen = 16'h0;
        d_addr = 24'h000010;
        d_wdata = 16'hBEEF;
        d_we = 1'b1;
        d_be = be;
        d_req = 1'b1;
        for (int c = 1; c <= 30 && ack_c == 0; c++) begin
            @(negedge clk);
            if (!bus_wr_n) begin
                nw++;
                seen = {seen[7:0], bus_out};
            end
            if (d_ack) begin ack_c = c; d_req = 1'b0; end
        end
        d_we = 1'b0;
        exp_seen = (be == 2'b11) ? 16'hEFBE :
                   (be == 2'b10) ? 16'h00BE : 16'h0000;
        n_cmp++;
        if (ack_c !== exp_ack) begin
            n_bad++;
            $display("FAIL w%b_latency: got %0d want %0d",
                     be, ack_c, exp_ack);
        end
        n_cmp++;
        if (nw !== exp_wr || seen !== exp_seen) begin
            n_bad++;
            $display("FAIL w%b_bytes: got %0d/%h want %0d/%h",
                     be, nw, seen, exp_wr, exp_seen);
        end
        n_cmp++;
        if (d_rdata !== 16'h7777) begin
            n_bad++;
            $display("FAIL w%b_rdata: got %h want 7777", be, d_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_wait_read();
        int ack_c;
        int nr;
        ack_c = 0; nr = 0;
        x_d_addr = 24'h000020;
        x_d_we = 1'b0;
        x_d_req = 1'b1;
        for (int c = 1; c <= 40 && ack_c == 0; c++) begin
            @(negedge clk);
            if (!x_rd_n) nr++;
            if (c == 8)       x_bus_in = 8'h5A;
            else if (c == 12) x_bus_in = 8'hA5;
            else              x_bus_in = 8'(c) ^ 8'hF0;
            if (x_d_ack) begin ack_c = c; x_d_req = 1'b0; end
        end
        n_cmp++;
        if (nr !== 8) begin
            n_bad++;
            $display("FAIL wait_rd_cycles: got %0d want 8", nr);
        end
        n_cmp++;
        if (ack_c !== 13) begin
            n_bad++;
            $display("FAIL wait_latency: got %0d want 13", ack_c);
        end
        n_cmp++;
        if (x_d_rdata !== 16'hA55A) begin
            n_bad++;
            $display("FAIL wait_rdata: got %h want a55a", x_d_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        int ack_c;
        acks = 0; ack_c = 0;
        d_addr = 24'h400040;
        d_we = 1'b0;
        d_req = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bus_rd_n !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_in_d0: got rd_n %b want 0", bus_rd_n);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus_rd_n, bus_oe, bus_ale, busy, d_ack} !== 13'h1000) begin
            n_bad++;
            $display("FAIL mid_async: got %h want 1000",
                     {bus_rd_n, bus_oe, bus_ale, busy, d_ack});
        end
        repeat (2) begin
            @(negedge clk);
            if (d_ack) acks++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus_ale !== 2'd3 || bus_out !== 8'h40 || acks !== 0) begin
            n_bad++;
            $display("FAIL mid_restart: got %0d/%h/%0d want 3/40/0",
                     bus_ale, bus_out, acks);
        end
        for (int c = 2; c <= 30 && ack_c == 0; c++) begin
            @(negedge clk);
            if (d_ack) begin ack_c = c; d_req = 1'b0; end
        end
        n_cmp++;
        if (ack_c !== 7) begin
            n_bad++;
            $display("FAIL mid_complete: got %0d want 7", ack_c);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_i_read();
        test_d_write(2'b11, 6, 2);
        test_d_write(2'b10, 5, 1);
        test_d_write(2'b00, 4, 0);
        test_wait_read();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
